filter_mode_ctrl: RTL and testbench
===================================

# filter_mode_ctrl

Frame-synchronous controller that drives the 3-bit `filter_sel` of the image filter stage. It takes user next/prev button levels and an optional auto-cycle enable, and queues mode changes. Changes are committed only on a frame boundary, so the displayed filter never switches mid-frame. After each commit it applies a short lockout against button bounce and repeated presses.

## Interface
Parameters:
- NUM_MODES, 5, number of legal filter modes (0..NUM_MODES-1), 2..8
- AUTO_FRAMES, 120, frames between automatic advances when auto_en=1, ≥1
- LOCK_FRAMES, 2, frames of button lockout after each commit, ≥0

Ports:
- clk  input  1  system/pixel clock
- reset  input  1  asynchronous, active-low reset
- btn_next  input  1  synchronized, debounced level; rising edge = advance request
- btn_prev  input  1  synchronized, debounced level; rising edge = retreat request
- auto_en  input  1  level; enables automatic cycling
- frame_tick  input  1  one-cycle pulse at start of vertical blanking
- filter_sel  output  3  committed mode to filter stage (registered)
- pending_sel  output  3  queued target mode (registered)
- sel_changed  output  1  one-cycle pulse, filter_sel updated this cycle
- locked  output  1  high while in LOCK state

## Operation
- Edge detect: btn_*_q registers hold the previous samples. next_edge = btn_next & ~btn_next_q, and prev_edge likewise. Both edges in the same cycle cancel and no request is made.
- Mode arithmetic: next = (m == NUM_MODES-1) ? 0 : m+1. prev = (m == 0) ? NUM_MODES-1 : m-1. Arithmetic is applied to pending_sel, never to filter_sel, so multiple presses accumulate.
- States:
  - IDLE: pending_sel == filter_sel.
    - An edge sets pending_sel = next/prev(pending_sel), clears the auto counter, and moves to PEND.
    - If auto_en=1, auto_cnt increments on each frame_tick. On the tick where auto_cnt == AUTO_FRAMES-1: pending_sel = next(filter_sel), auto_cnt=0, moves to PEND (committed on the following tick).
    - auto_en=0 holds auto_cnt at 0.
  - PEND:
    - An edge updates pending_sel relative to the current pending_sel.
    - On frame_tick: filter_sel = pending_sel, sel_changed=1. Goes to LOCK with lock_cnt=0, or to IDLE if LOCK_FRAMES=0.
    - If accumulated presses return pending_sel to filter_sel, the state remains PEND. The commit still occurs with an unchanged value and sel_changed still pulses.
  - LOCK:
    - Button edges are dropped. auto_cnt is held.
    - lock_cnt increments on each frame_tick. On the tick where lock_cnt == LOCK_FRAMES-1, the state goes to IDLE.
- Edge registers update in every state, so a button held through LOCK does not fire on exit.
- auto_cnt width is clog2(AUTO_FRAMES). lock_cnt width is clog2(LOCK_FRAMES+1). Counters never wrap past their terminal values.

## Timing
- Reset (reset=0, async):
  - filter_sel=0, pending_sel=0, sel_changed=0, locked=0
  - state=IDLE, auto_cnt=0, lock_cnt=0, btn_*_q=0
- Edge sampled at clock edge k: pending_sel reflects it after edge k.
- frame_tick high at edge m in PEND: filter_sel and sel_changed are valid after edge m; sel_changed drops after edge m+1.
- Edge and frame_tick at the same clock edge:
  - In IDLE: the press is queued, state goes to PEND, and the commit waits for the next tick.
  - In PEND: the tick commits the old pending_sel. pending_sel takes the press result, and the state goes to LOCK. pending_sel then remains ≠ filter_sel until LOCK exits to PEND.
- Precedence rule on LOCK exit: if pending_sel ≠ filter_sel, the state goes to PEND instead of IDLE.
- Reset asserted mid-PEND or mid-LOCK discards the queued mode. filter_sel returns to 0 immediately, without waiting for a frame.
- frame_tick is assumed never high on consecutive cycles. Each cycle it is high counts once.

## Test plan
- Reset: drive reset=0 mid-frame with filter_sel=3 -> all outputs 0 asynchronously; after release, state is IDLE and filter_sel=0.
- Single press: btn_next pulse from mode 0, frame_tick 50 cycles later -> pending_sel=1 one cycle after the edge; filter_sel=1 with a one-cycle sel_changed exactly at the tick; locked=1 for 2 ticks, then 0.
- Accumulate/wrap: from mode 0, three btn_prev edges in one frame -> pending_sel 4,3,2; commit gives filter_sel=2. A separate case with simultaneous next+prev -> no change, state stays IDLE.
- Lockout: press during LOCK -> pending_sel unchanged and no commit. Press immediately after LOCK exits -> accepted.
- Auto cycle: AUTO_FRAMES=3, LOCK_FRAMES=0, auto_en=1 -> filter_sel steps 0→1→2→3→4→0, advancing every 4 ticks (3 counting ticks + 1 commit tick). Dropping auto_en mid-count -> counter clears and no advance occurs.
- Same-edge collision: btn_next edge coincident with frame_tick in PEND (pending=2, sel=1) -> filter_sel=2, pending_sel=3. After the lockout ends -> PEND, and filter_sel=3 at the next tick.

Source files
------------

// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl
// Frame-synchronous mode controller for the image filter stage. Button edges
// and an optional auto-cycle timer queue a target mode in pending_sel. The
// queued mode is committed to filter_sel only on frame_tick, so the filter
// never switches mid-frame. Each commit is followed by a short lockout that
// drops button edges.
//
// Ports:
//   clk          system/pixel clock
//   reset        asynchronous active-low reset
//   btn_next     debounced level; rising edge requests the next mode
//   btn_prev     debounced level; rising edge requests the previous mode
//   auto_en      level; enables automatic cycling every AUTO_FRAMES frames
//   frame_tick   one-cycle pulse at start of vertical blanking
//   filter_sel   committed mode (registered)
//   pending_sel  queued target mode (registered)
//   sel_changed  one-cycle pulse when filter_sel is written (registered)
//   locked       high while in the lockout state (registered)

module filter_mode_ctrl #(
  parameter int unsigned NUM_MODES   = 5,
  parameter int unsigned AUTO_FRAMES = 120,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  input  logic       frame_tick,
  output logic [2:0] filter_sel,
  output logic [2:0] pending_sel,
  output logic       sel_changed,
  output logic       locked
);

  localparam int unsigned SEL_W  = 3;
  // Keep counters at least one bit wide for the degenerate parameter values.
  localparam int unsigned AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int unsigned LOCK_W = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

  localparam logic [SEL_W-1:0]  LAST_MODE = SEL_W'(NUM_MODES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   filter_q, filter_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic               sel_changed_q, sel_changed_d;
  logic               locked_q, locked_d;
  logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic               btn_next_q, btn_prev_q;

  logic               next_edge, prev_edge;
  logic               req_next, req_prev, req_any;
  logic [SEL_W-1:0]   pending_req;

  // Wrapping mode arithmetic over 0..NUM_MODES-1.
  function automatic logic [SEL_W-1:0] mode_next(input logic [SEL_W-1:0] m);
    return (m == LAST_MODE) ? '0 : m + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] mode_prev(input logic [SEL_W-1:0] m);
    return (m == '0) ? LAST_MODE : m - SEL_W'(1);
  endfunction

  // Rising-edge detect; simultaneous next+prev edges cancel each other.
  always_comb begin
    next_edge   = btn_next & ~btn_next_q;
    prev_edge   = btn_prev & ~btn_prev_q;
    req_next    = next_edge & ~prev_edge;
    req_prev    = prev_edge & ~next_edge;
    req_any     = req_next | req_prev;
    pending_req = pending_q;
    if (req_next) begin
      pending_req = mode_next(pending_q);
    end else if (req_prev) begin
      pending_req = mode_prev(pending_q);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    filter_d      = filter_q;
    pending_d     = pending_q;
    sel_changed_d = 1'b0;
    auto_cnt_d    = auto_en ? auto_cnt_q : '0;
    lock_cnt_d    = lock_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          // A press takes precedence over a coincident auto tick.
          pending_d  = pending_req;
          auto_cnt_d = '0;
          state_d    = ST_PEND;
        end else if (auto_en && frame_tick) begin
          if (auto_cnt_q == AUTO_LAST) begin
            pending_d  = mode_next(filter_q);
            auto_cnt_d = '0;
            state_d    = ST_PEND;
          end else begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
          end
        end
      end

      ST_PEND: begin
        pending_d = pending_req;
        if (frame_tick) begin
          // Commit the value queued before this edge; a coincident press
          // stays queued for the next commit.
          filter_d      = pending_q;
          sel_changed_d = 1'b1;
          lock_cnt_d    = '0;
          if (LOCK_FRAMES == 0) begin
            state_d = (pending_req != pending_q) ? ST_PEND : ST_IDLE;
          end else begin
            state_d = ST_LOCK;
          end
        end
      end

      ST_LOCK: begin
        auto_cnt_d = auto_cnt_q;
        if (frame_tick) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d = (pending_q != filter_q) ? ST_PEND : ST_IDLE;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    locked_d = (state_d == ST_LOCK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      filter_q      <= '0;
      pending_q     <= '0;
      sel_changed_q <= 1'b0;
      locked_q      <= 1'b0;
      auto_cnt_q    <= '0;
      lock_cnt_q    <= '0;
      btn_next_q    <= 1'b0;
      btn_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      filter_q      <= filter_d;
      pending_q     <= pending_d;
      sel_changed_q <= sel_changed_d;
      locked_q      <= locked_d;
      auto_cnt_q    <= auto_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      // Edge history updates in every state so a press held through the
      // lockout does not fire on exit.
      btn_next_q    <= btn_next;
      btn_prev_q    <= btn_prev;
    end
  end

  assign filter_sel  = filter_q;
  assign pending_sel = pending_q;
  assign sel_changed = sel_changed_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Testbench for filter_mode_ctrl: a default-parameter instance for button
// behaviour and a fast auto-cycle instance (AUTO_FRAMES=3, LOCK_FRAMES=0).
// Expected committed modes are queued when stimulus is applied and popped
// whenever a DUT pulses sel_changed.

module tb_filter_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next, btn_prev, auto_en, frame_tick;
  logic       btn_zero, auto_en_a;
  logic [2:0] filter_sel, pending_sel, filter_sel_a, pending_sel_a;
  logic       sel_changed, locked, sel_changed_a, locked_a;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_qa[$];
  logic [2:0] exp_m, exp_a;

  always #5 clk = ~clk;

  filter_mode_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .frame_tick  (frame_tick),
    .filter_sel  (filter_sel),
    .pending_sel (pending_sel),
    .sel_changed (sel_changed),
    .locked      (locked)
  );

  filter_mode_ctrl #(.NUM_MODES(5), .AUTO_FRAMES(3), .LOCK_FRAMES(0)) u_auto (
    .clk         (clk),
    .reset       (reset),
    .btn_next    (btn_zero),
    .btn_prev    (btn_zero),
    .auto_en     (auto_en_a),
    .frame_tick  (frame_tick),
    .filter_sel  (filter_sel_a),
    .pending_sel (pending_sel_a),
    .sel_changed (sel_changed_a),
    .locked      (locked_a)
  );

  // Scoreboard: every commit pulse must match the next queued mode.
  always @(negedge clk) begin
    if (sel_changed === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL main_commit: unexpected commit filter_sel=%0d, expected none", filter_sel);
      end else begin
        exp_m = exp_q.pop_front();
        if (filter_sel !== exp_m) begin
          n_fail++;
          $display("FAIL main_commit: filter_sel=%0d expected %0d", filter_sel, exp_m);
        end
      end
    end
    if (sel_changed_a === 1'b1) begin
      n_checks++;
      if (exp_qa.size() == 0) begin
        n_fail++;
        $display("FAIL auto_commit: unexpected commit filter_sel=%0d, expected none", filter_sel_a);
      end else begin
        exp_a = exp_qa.pop_front();
        if (filter_sel_a !== exp_a) begin
          n_fail++;
          $display("FAIL auto_commit: filter_sel=%0d expected %0d", filter_sel_a, exp_a);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_next();
    btn_next = 1'b1;
    cyc();
    btn_next = 1'b0;
  endtask

  task automatic pulse_prev();
    btn_prev = 1'b1;
    cyc();
    btn_prev = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_next = 0; btn_prev = 0; btn_zero = 0;
    auto_en = 0; auto_en_a = 0; frame_tick = 0;
    #2;
    n_checks++; if (filter_sel !== 3'd0) begin n_fail++; $display("FAIL reset_filter: got %0d expected 0", filter_sel); end
    n_checks++; if (pending_sel !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending_sel); end
    n_checks++; if (sel_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b expected 0", sel_changed); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    @(posedge clk); #2; reset = 1'b1;
    cyc();
    n_checks++; if (filter_sel_a !== 3'd0) begin n_fail++; $display("FAIL reset_auto_filter: got %0d expected 0", filter_sel_a); end
  endtask

  task automatic test_single_press();
    pulse_next();
    n_checks++; if (pending_sel !== 3'd1) begin n_fail++; $display("FAIL press_pending: got %0d expected 1", pending_sel); end
    n_checks++; if (filter_sel !== 3'd0) begin n_fail++; $display("FAIL press_filter_hold: got %0d expected 0", filter_sel); end
    idle(50);
    n_checks++; if (filter_sel !== 3'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL press_wait: filter=%0d locked=%b expected 0/0", filter_sel, locked); end
    exp_q.push_back(3'd1);
    pulse_tick();
    n_checks++; if (filter_sel !== 3'd1 || sel_changed !== 1'b1) begin n_fail++; $display("FAIL press_commit: filter=%0d changed=%b expected 1/1", filter_sel, sel_changed); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL press_locked: got %b expected 1", locked); end
    cyc();
    n_checks++; if (sel_changed !== 1'b0) begin n_fail++; $display("FAIL press_pulse_width: sel_changed=%b expected 0", sel_changed); end
    idle(5); pulse_tick();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL press_lock_tick1: locked=%b expected 1", locked); end
    idle(5); pulse_tick();
    n_checks++; if (locked !== 1'b0 || filter_sel !== 3'd1 || pending_sel !== 3'd1) begin n_fail++; $display("FAIL press_unlock: locked=%b filter=%0d pending=%0d expected 0/1/1", locked, filter_sel, pending_sel); end
  endtask

  task automatic test_lockout();
    pulse_next();
    n_checks++; if (pending_sel !== 3'd2) begin n_fail++; $display("FAIL lock_pending: got %0d expected 2", pending_sel); end
    idle(3); exp_q.push_back(3'd2); pulse_tick();
    n_checks++; if (filter_sel !== 3'd2 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_commit: filter=%0d locked=%b expected 2/1", filter_sel, locked); end
    idle(2); pulse_next();
    n_checks++; if (pending_sel !== 3'd2) begin n_fail++; $display("FAIL lock_drop: pending=%0d expected 2", pending_sel); end
    idle(3); pulse_tick();
    n_checks++; if (sel_changed !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_no_commit: changed=%b locked=%b expected 0/1", sel_changed, locked); end
    idle(3); pulse_tick();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_exit: locked=%b expected 0", locked); end
    pulse_next();
    n_checks++; if (pending_sel !== 3'd3) begin n_fail++; $display("FAIL lock_after_exit: pending=%0d expected 3", pending_sel); end
    idle(3); exp_q.push_back(3'd3); pulse_tick();
    n_checks++; if (filter_sel !== 3'd3) begin n_fail++; $display("FAIL lock_commit2: filter=%0d expected 3", filter_sel); end
    idle(3); pulse_tick(); idle(3); pulse_tick();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_exit2: locked=%b expected 0", locked); end
  endtask

  task automatic test_async_reset();
    pulse_next();
    n_checks++; if (pending_sel !== 3'd4 || filter_sel !== 3'd3) begin n_fail++; $display("FAIL areset_setup: pending=%0d filter=%0d expected 4/3", pending_sel, filter_sel); end
    idle(5);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (filter_sel !== 3'd0 || pending_sel !== 3'd0) begin n_fail++; $display("FAIL areset_async: filter=%0d pending=%0d expected 0/0", filter_sel, pending_sel); end
    n_checks++; if (sel_changed !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL areset_flags: changed=%b locked=%b expected 0/0", sel_changed, locked); end
    #2 reset = 1'b1;
    cyc();
    idle(3); pulse_tick();
    n_checks++; if (sel_changed !== 1'b0 || filter_sel !== 3'd0 || pending_sel !== 3'd0) begin n_fail++; $display("FAIL areset_idle: changed=%b filter=%0d pending=%0d expected 0/0/0", sel_changed, filter_sel, pending_sel); end
  endtask

  task automatic test_accumulate();
    pulse_prev();
    n_checks++; if (pending_sel !== 3'd4) begin n_fail++; $display("FAIL accum_prev1: pending=%0d expected 4", pending_sel); end
    cyc(); pulse_prev();
    n_checks++; if (pending_sel !== 3'd3) begin n_fail++; $display("FAIL accum_prev2: pending=%0d expected 3", pending_sel); end
    cyc(); pulse_prev();
    n_checks++; if (pending_sel !== 3'd2 || filter_sel !== 3'd0) begin n_fail++; $display("FAIL accum_prev3: pending=%0d filter=%0d expected 2/0", pending_sel, filter_sel); end
    idle(3); exp_q.push_back(3'd2); pulse_tick();
    n_checks++; if (filter_sel !== 3'd2 || sel_changed !== 1'b1) begin n_fail++; $display("FAIL accum_commit: filter=%0d changed=%b expected 2/1", filter_sel, sel_changed); end
    idle(3); pulse_tick(); idle(3); pulse_tick();
    btn_next = 1'b1; btn_prev = 1'b1;
    cyc();
    btn_next = 1'b0; btn_prev = 1'b0;
    n_checks++; if (pending_sel !== 3'd2) begin n_fail++; $display("FAIL both_cancel: pending=%0d expected 2", pending_sel); end
    idle(3); pulse_tick();
    n_checks++; if (sel_changed !== 1'b0 || locked !== 1'b0 || filter_sel !== 3'd2) begin n_fail++; $display("FAIL both_idle: changed=%b locked=%b filter=%0d expected 0/0/2", sel_changed, locked, filter_sel); end
  endtask

  task automatic test_collision();
    pulse_prev();
    idle(3); exp_q.push_back(3'd1); pulse_tick();
    n_checks++; if (filter_sel !== 3'd1) begin n_fail++; $display("FAIL coll_setup: filter=%0d expected 1", filter_sel); end
    idle(3); pulse_tick(); idle(3); pulse_tick();
    pulse_next();
    n_checks++; if (pending_sel !== 3'd2 || locked !== 1'b0) begin n_fail++; $display("FAIL coll_pending: pending=%0d locked=%b expected 2/0", pending_sel, locked); end
    cyc();
    exp_q.push_back(3'd2);
    btn_next = 1'b1; frame_tick = 1'b1;
    cyc();
    btn_next = 1'b0; frame_tick = 1'b0;
    n_checks++; if (filter_sel !== 3'd2 || pending_sel !== 3'd3) begin n_fail++; $display("FAIL coll_same_edge: filter=%0d pending=%0d expected 2/3", filter_sel, pending_sel); end
    n_checks++; if (sel_changed !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL coll_flags: changed=%b locked=%b expected 1/1", sel_changed, locked); end
    idle(3); pulse_tick();
    n_checks++; if (locked !== 1'b1 || filter_sel !== 3'd2) begin n_fail++; $display("FAIL coll_lock: locked=%b filter=%0d expected 1/2", locked, filter_sel); end
    idle(3); pulse_tick();
    n_checks++; if (locked !== 1'b0 || pending_sel !== 3'd3 || filter_sel !== 3'd2 || sel_changed !== 1'b0) begin n_fail++; $display("FAIL coll_to_pend: locked=%b pending=%0d filter=%0d changed=%b expected 0/3/2/0", locked, pending_sel, filter_sel, sel_changed); end
    idle(3); exp_q.push_back(3'd3); pulse_tick();
    n_checks++; if (filter_sel !== 3'd3 || sel_changed !== 1'b1) begin n_fail++; $display("FAIL coll_commit: filter=%0d changed=%b expected 3/1", filter_sel, sel_changed); end
    idle(3); pulse_tick(); idle(3); pulse_tick();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL coll_exit: locked=%b expected 0", locked); end
  endtask

  task automatic test_auto();
    logic [2:0] exp_mode;
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    cyc();
    n_checks++; if (filter_sel_a !== 3'd0) begin n_fail++; $display("FAIL auto_reset: filter=%0d expected 0", filter_sel_a); end
    auto_en_a = 1'b1;
    for (int step = 0; step < 5; step++) begin
      exp_mode = 3'((step + 1) % 5);
      exp_qa.push_back(exp_mode);
      for (int t = 0; t < 3; t++) begin
        idle(3); pulse_tick();
        n_checks++; if (sel_changed_a !== 1'b0) begin n_fail++; $display("FAIL auto_count step%0d tick%0d: changed=%b expected 0", step, t, sel_changed_a); end
      end
      n_checks++; if (pending_sel_a !== exp_mode) begin n_fail++; $display("FAIL auto_pending step%0d: pending=%0d expected %0d", step, pending_sel_a, exp_mode); end
      idle(3); pulse_tick();
      n_checks++; if (filter_sel_a !== exp_mode || sel_changed_a !== 1'b1) begin n_fail++; $display("FAIL auto_step%0d: filter=%0d changed=%b expected %0d/1", step, filter_sel_a, sel_changed_a, exp_mode); end
    end
    idle(3); pulse_tick(); idle(3); pulse_tick();
    auto_en_a = 1'b0;
    idle(3); pulse_tick();
    n_checks++; if (pending_sel_a !== 3'd0 || filter_sel_a !== 3'd0) begin n_fail++; $display("FAIL auto_disabled: pending=%0d filter=%0d expected 0/0", pending_sel_a, filter_sel_a); end
    auto_en_a = 1'b1;
    idle(3); pulse_tick(); idle(3); pulse_tick();
    n_checks++; if (pending_sel_a !== 3'd0) begin n_fail++; $display("FAIL auto_cleared: pending=%0d expected 0", pending_sel_a); end
    idle(3); pulse_tick();
    n_checks++; if (pending_sel_a !== 3'd1) begin n_fail++; $display("FAIL auto_resume: pending=%0d expected 1", pending_sel_a); end
    exp_qa.push_back(3'd1);
    idle(3); pulse_tick();
    n_checks++; if (filter_sel_a !== 3'd1) begin n_fail++; $display("FAIL auto_resume_commit: filter=%0d expected 1", filter_sel_a); end
    auto_en_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_lockout();
    test_async_reset();
    test_accumulate();
    test_collision();
    test_auto();
    idle(5);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL main_queue_drain: %0d commits outstanding, expected 0", exp_q.size()); end
    n_checks++; if (exp_qa.size() != 0) begin n_fail++; $display("FAIL auto_queue_drain: %0d commits outstanding, expected 0", exp_qa.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
